// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared state encoding and defaults for the fifo round-robin scheduler
package fifo_sched_pkg;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam int DEF_NUM_FIFOS  = 4;
  localparam int DEF_DATA_WIDTH = 10;

  typedef enum logic [2:0] {
    S_RESET  = ST_RESET,
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_ERROR  = ST_ERROR
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after the last granted index
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int IDX_W     = $clog2(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req_i,
  input  logic [NUM_FIFOS-1:0] mask_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  input  logic                 enable_i,
  output logic [NUM_FIFOS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk indices last+1 .. last+NUM_FIFOS; power-of-2 width makes the wrap free.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int i = 1; i <= NUM_FIFOS; i++) begin
      idx = last_grant_i + IDX_W'(i);
      if (enable_i && !found && req_i[idx] && !mask_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - configures a fifo bank and drains it round-robin into one downstream fifo
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_FIFOS    = DEF_NUM_FIFOS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int UMBRAL_WIDTH = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init,
  input  logic [UMBRAL_WIDTH-1:0]         umbral_bajo_in,
  input  logic [UMBRAL_WIDTH-1:0]         umbral_alto_in,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS-1:0]            fifo_error,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data,
  input  logic                            out_almost_full,
  output logic [UMBRAL_WIDTH-1:0]         umbral_bajo_out,
  output logic [UMBRAL_WIDTH-1:0]         umbral_alto_out,
  output logic [NUM_FIFOS-1:0]            pop,
  output logic                            push_out,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [2:0]                      state,
  output logic                            idle_out,
  output logic                            error_out,
  output logic [CNT_WIDTH-1:0]            words_sent
);

  localparam int IDX_W = $clog2(NUM_FIFOS);

  sched_state_e            state_q, state_d;
  logic                    idle_q, error_q;
  logic [UMBRAL_WIDTH-1:0] bajo_q, alto_q;
  logic [NUM_FIFOS-1:0]    pop_q;
  logic                    push_q;
  logic [IDX_W-1:0]        sel_q, last_q;
  logic [CNT_WIDTH-1:0]    words_q;

  logic [NUM_FIFOS-1:0]    grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    arb_en, any_err, all_empty, any_pop;

  assign any_err   = |fifo_error;
  assign all_empty = &fifo_empty;
  assign arb_en    = (state_q == S_ACTIVE) && !out_almost_full;
  assign any_pop   = |grant;

  // The fifo empty flag lags a pop by one cycle, so last cycle's pop masks its source.
  rr_arbiter #(
    .NUM_FIFOS (NUM_FIFOS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req_i        (~fifo_empty),
    .mask_i       (pop_q),
    .last_grant_i (last_q),
    .enable_i     (arb_en),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // Next-state selection: error beats init, init beats the traffic-driven moves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT: begin
        if (any_err)        state_d = S_ERROR;
        else if (init)      state_d = S_INIT;
        else if (all_empty) state_d = S_IDLE;
        else                state_d = S_ACTIVE;
      end
      S_IDLE: begin
        if (any_err)         state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (!all_empty) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_err)                   state_d = S_ERROR;
        else if (init)                 state_d = S_INIT;
        else if (all_empty && !any_pop) state_d = S_IDLE;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
  end

  // FSM register with registered status flags and threshold capture while in INIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RESET;
      idle_q  <= 1'b0;
      error_q <= 1'b0;
      bajo_q  <= '0;
      alto_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == S_IDLE);
      error_q <= (state_d == S_ERROR);
      if (state_q == S_INIT && init) begin
        bajo_q <= umbral_bajo_in;
        alto_q <= umbral_alto_in;
      end
    end
  end

  // Pop-to-push pipeline and word counter; a push in flight always lands unless reset hits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q   <= '0;
      push_q  <= 1'b0;
      sel_q   <= '0;
      last_q  <= IDX_W'(NUM_FIFOS - 1);
      words_q <= '0;
    end else begin
      pop_q  <= grant;
      push_q <= any_pop;
      if (any_pop) begin
        sel_q  <= grant_idx;
        last_q <= grant_idx;
      end
      if (push_q) words_q <= words_q + CNT_WIDTH'(1);
    end
  end

  assign pop             = grant;
  assign push_out        = push_q;
  assign data_out        = push_q ? fifo_data[sel_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign state           = state_q;
  assign idle_out        = idle_q;
  assign error_out       = error_q;
  assign umbral_bajo_out = bajo_q;
  assign umbral_alto_out = alto_q;
  assign words_sent      = words_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - scoreboard bench for the fifo round-robin scheduler
module tb_fifo_rr_scheduler;
  import fifo_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset, init, out_almost_full;
  logic [7:0]  umbral_bajo_in, umbral_alto_in, umbral_bajo_out, umbral_alto_out;
  logic [3:0]  fifo_empty, fifo_error, pop;
  logic [39:0] fifo_data;
  logic        push_out, idle_out, error_out;
  logic [9:0]  data_out;
  logic [2:0]  state;
  logic [15:0] words_sent;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_pop_q[$];
  logic [9:0] exp_data_q[$];
  logic [3:0] m_pop;
  logic [9:0] m_data;

  logic [7:0]  s_bajo, s_alto;
  logic        s_push, s_idle, s_err;
  logic [9:0]  s_data;
  logic [15:0] s_words;

  always #5 clk = ~clk;

  fifo_rr_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_bajo_in  (umbral_bajo_in),
    .umbral_alto_in  (umbral_alto_in),
    .fifo_empty      (fifo_empty),
    .fifo_error      (fifo_error),
    .fifo_data       (fifo_data),
    .out_almost_full (out_almost_full),
    .umbral_bajo_out (umbral_bajo_out),
    .umbral_alto_out (umbral_alto_out),
    .pop             (pop),
    .push_out        (push_out),
    .data_out        (data_out),
    .state           (state),
    .idle_out        (idle_out),
    .error_out       (error_out),
    .words_sent      (words_sent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word held by each source: fifo0=3A1, fifo1=155, fifo2=2CC, fifo3=0F3.
  function automatic logic [9:0] slice_of(input logic [3:0] onehot);
    case (onehot)
      4'b0001: slice_of = 10'h3A1;
      4'b0010: slice_of = 10'h155;
      4'b0100: slice_of = 10'h2CC;
      default: slice_of = 10'h0F3;
    endcase
  endfunction

  // Monitor: compare pop every scheduled cycle and each presented push against the queue.
  always @(negedge clk) begin
    if (exp_pop_q.size() > 0) begin
      m_pop = exp_pop_q.pop_front();
      chk("pop", {28'd0, pop}, {28'd0, m_pop});
    end
    if (push_out) begin
      if (exp_data_q.size() == 0) begin
        chk("push_out_unexpected", {31'd0, push_out}, 32'd0);
      end else begin
        m_data = exp_data_q.pop_front();
        chk("data_out", {22'd0, data_out}, {22'd0, m_data});
      end
    end
  end

  // One clock cycle: queue expectations, check state at mid-cycle, capture outputs.
  task automatic cyc(input logic [2:0] es, input logic [3:0] ep, input bit drop);
    exp_pop_q.push_back(ep);
    if (ep != 4'b0000 && !drop) exp_data_q.push_back(slice_of(ep));
    @(negedge clk);
    #1;
    chk("state", {29'd0, state}, {29'd0, es});
    s_bajo  = umbral_bajo_out;
    s_alto  = umbral_alto_out;
    s_push  = push_out;
    s_data  = data_out;
    s_idle  = idle_out;
    s_err   = error_out;
    s_words = words_sent;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bajo"},  {24'd0, s_bajo}, 32'd0);
    chk({tag, "_alto"},  {24'd0, s_alto}, 32'd0);
    chk({tag, "_push"},  {31'd0, s_push}, 32'd0);
    chk({tag, "_data"},  {22'd0, s_data}, 32'd0);
    chk({tag, "_words"}, {16'd0, s_words}, 32'd0);
    chk({tag, "_idle"},  {31'd0, s_idle}, 32'd0);
    chk({tag, "_err"},   {31'd0, s_err}, 32'd0);
  endtask

  initial begin
    reset           = 1'b0;
    init            = 1'b0;
    umbral_bajo_in  = 8'd0;
    umbral_alto_in  = 8'd0;
    fifo_empty      = 4'b1111;
    fifo_error      = 4'b0000;
    out_almost_full = 1'b0;
    fifo_data       = {10'h0F3, 10'h2CC, 10'h155, 10'h3A1};
    @(posedge clk);
    #1;

    // Reset, threshold load, settle in IDLE
    cyc(ST_RESET, 4'b0000, 1'b0);
    chk_all_zero("reset");
    cyc(ST_RESET, 4'b0000, 1'b0);
    reset = 1'b1; init = 1'b1; umbral_bajo_in = 8'd2; umbral_alto_in = 8'd6;
    cyc(ST_RESET, 4'b0000, 1'b0);
    cyc(ST_INIT, 4'b0000, 1'b0);
    init = 1'b0;
    cyc(ST_INIT, 4'b0000, 1'b0);
    chk("umbral_bajo_init", {24'd0, s_bajo}, 32'd2);
    chk("umbral_alto_init", {24'd0, s_alto}, 32'd6);
    cyc(ST_IDLE, 4'b0000, 1'b0);
    chk("idle_out", {31'd0, s_idle}, 32'd1);

    // All sources full: plain rotation 0,1,2,3
    fifo_empty = 4'b0000;
    cyc(ST_IDLE, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(ST_ACTIVE, 4'b0001 << (i % 4), 1'b0);
      if (i == 0) begin
        chk("idle_out_active", {31'd0, s_idle}, 32'd0);
        chk("first_push_latency", {31'd0, s_push}, 32'd0);
      end
      if (i == 1) chk("push_second_cycle", {31'd0, s_push}, 32'd1);
    end

    // Lone source drains every other cycle
    fifo_empty = 4'b1011;
    cyc(ST_ACTIVE, 4'b0100, 1'b0);
    chk("words_after_8", {16'd0, s_words}, 32'd7);
    for (int i = 0; i < 5; i++) cyc(ST_ACTIVE, i[0] ? 4'b0100 : 4'b0000, 1'b0);

    // Backpressure: one trailing push, then resume after last grant
    fifo_empty = 4'b0000;
    cyc(ST_ACTIVE, 4'b1000, 1'b0);
    out_almost_full = 1'b1;
    cyc(ST_ACTIVE, 4'b0000, 1'b0);
    chk("trailing_push", {31'd0, s_push}, 32'd1);
    cyc(ST_ACTIVE, 4'b0000, 1'b0);
    chk("no_push_backpressure", {31'd0, s_push}, 32'd0);
    cyc(ST_ACTIVE, 4'b0000, 1'b0);
    out_almost_full = 1'b0;
    cyc(ST_ACTIVE, 4'b0001, 1'b0);
    cyc(ST_ACTIVE, 4'b0010, 1'b0);

    // Re-init during traffic
    init = 1'b1; umbral_bajo_in = 8'd1; umbral_alto_in = 8'd7;
    cyc(ST_ACTIVE, 4'b0100, 1'b0);
    chk("words_mid", {16'd0, s_words}, 32'd13);
    cyc(ST_INIT, 4'b0000, 1'b0);
    chk("push_completes_in_init", {31'd0, s_push}, 32'd1);
    init = 1'b0;
    cyc(ST_INIT, 4'b0000, 1'b0);
    chk("umbral_bajo_reinit", {24'd0, s_bajo}, 32'd1);
    chk("umbral_alto_reinit", {24'd0, s_alto}, 32'd7);
    cyc(ST_ACTIVE, 4'b1000, 1'b0);
    cyc(ST_ACTIVE, 4'b0001, 1'b0);

    // Error is sticky until reset
    fifo_error = 4'b0010;
    cyc(ST_ACTIVE, 4'b0010, 1'b0);
    fifo_error = 4'b0000;
    cyc(ST_ERROR, 4'b0000, 1'b0);
    chk("error_out", {31'd0, s_err}, 32'd1);
    chk("push_completes_in_error", {31'd0, s_push}, 32'd1);
    cyc(ST_ERROR, 4'b0000, 1'b0);
    chk("no_push_in_error", {31'd0, s_push}, 32'd0);
    reset = 1'b0;
    cyc(ST_ERROR, 4'b0000, 1'b0);
    cyc(ST_RESET, 4'b0000, 1'b0);
    chk_all_zero("reset2");

    // Reset mid-transfer drops the pending push
    reset = 1'b1;
    cyc(ST_RESET, 4'b0000, 1'b0);
    cyc(ST_INIT, 4'b0000, 1'b0);
    cyc(ST_ACTIVE, 4'b0001, 1'b0);
    reset = 1'b0;
    cyc(ST_ACTIVE, 4'b0010, 1'b1);
    cyc(ST_RESET, 4'b0000, 1'b0);
    chk("push_dropped_on_reset", {31'd0, s_push}, 32'd0);
    reset = 1'b1;

    chk("pending_pushes", exp_data_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Controller that configures and drains NUM_FIFOS parallel fifo instances into a single downstream FIFO.
- Distributes umbral_bajo/umbral_alto thresholds to the fifos after reset.
- Grants pops round-robin and forwards the popped word with one push per transfer.
- Stops on downstream backpressure.
- Sits between the per-channel fifo bank and the output-stage fifo.

Parameters:
- NUM_FIFOS, 4, number of source fifos (power of 2, >=2).
- DATA_WIDTH, 10, word width of each fifo.
- UMBRAL_WIDTH, 8, threshold width.
- CNT_WIDTH, 16, transfer counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low.
- init  input  1  1 = (re)load thresholds.
- umbral_bajo_in  input  UMBRAL_WIDTH  almost-empty threshold to distribute.
- umbral_alto_in  input  UMBRAL_WIDTH  almost-full threshold to distribute.
- fifo_empty  input  NUM_FIFOS  empty flag per source fifo.
- fifo_error  input  NUM_FIFOS  error flag per source fifo.
- fifo_data  input  NUM_FIFOS*DATA_WIDTH  data_out of each fifo; fifo k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_almost_full  input  1  downstream fifo almost_full.
- umbral_bajo_out  output  UMBRAL_WIDTH  registered threshold to all fifos.
- umbral_alto_out  output  UMBRAL_WIDTH  registered threshold to all fifos.
- pop  output  NUM_FIFOS  one-hot read_enable to the source fifos.
- push_out  output  1  write_enable to the downstream fifo.
- data_out  output  DATA_WIDTH  word to the downstream fifo.
- state  output  3  current FSM state.
- idle_out  output  1  high in IDLE.
- error_out  output  1  high in ERROR.
- words_sent  output  CNT_WIDTH  count of push_out cycles.

Behaviour:
- Reset: reset sampled 0 at posedge -> state=RESET.
  - All outputs go to 0, including thresholds, pop, push_out, data_out and words_sent.
  - last_grant=NUM_FIFOS-1, so the first grant goes to fifo 0.
- States (encoding): RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Priority of transitions: error > init > others.
  - Any fifo_error bit set in a non-RESET state -> ERROR next cycle.
  - ERROR is sticky until reset.
- RESET -> INIT on the first cycle with reset=1.
- INIT:
  - While init=1, latch umbral_*_in into umbral_*_out every cycle.
  - When init=0: -> IDLE if fifo_empty is all 1s, else -> ACTIVE.
- IDLE:
  - init=1 -> INIT.
  - Any fifo_empty bit 0 -> ACTIVE.
  - Otherwise stay.
- ACTIVE:
  - init=1 -> INIT.
  - All fifos empty and no pop this cycle -> IDLE.
- Pops are issued only in ACTIVE.
  - A push already in flight completes in the following cycle regardless of state.
  - This includes transitions to INIT, IDLE and ERROR; it does not apply to reset.
- Arbitration (combinational, same cycle):
  - eligible[k] = ~fifo_empty[k] & ~(pop_q[k]), where pop_q is last cycle's pop.
  - The pop_q mask blocks back-to-back pops of one fifo, because empty lags by one cycle. A lone non-empty source therefore drains at most every other cycle.
  - Grant the first eligible index searching from last_grant+1, wrapping modulo NUM_FIFOS.
  - No grant if out_almost_full=1 or no index is eligible.
  - pop is one-hot or zero; last_grant updates only on a grant.
- Data path, 1-cycle latency:
  - pop[k] in cycle N -> push_out=1 in cycle N+1.
  - data_out = fifo_data slice sel_q in cycle N+1, where sel_q is the registered grant index.
  - push_out is never asserted without a pop in the previous cycle.
  - Downstream umbral_alto must leave >=1 free slot, since one push can follow the almost_full assertion.
- words_sent: increments on each push_out cycle; wraps from all-ones to 0.
- Reset mid-transfer: the pending push is dropped; push_out=0 the next cycle.

Decomposition:
- Package fifo_sched_pkg:
  - State encoding localparams: ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR.
  - Default NUM_FIFOS and DATA_WIDTH constants.
- Sub-module rr_arbiter (NUM_FIFOS parameter).
  - Inputs: req, mask, last_grant, enable.
  - Outputs: one-hot grant and its index.
  - Combinational rotate/priority logic.
- The top level holds the FSM, threshold registers, pipeline registers and counter.

Test Plan:
1. Reset low for 2 cycles, then init=1 with umbral_bajo_in=2, umbral_alto_in=6, then init=0 with all fifos empty -> state 0->1->2; umbral outputs 2/6; pop=0.
2. fifo_empty=4'b0000, out_almost_full=0, held 8 cycles -> pop sequence 0001, 0010, 0100, 1000, repeating. push_out=1 from the second cycle; data_out follows each slice one cycle later; words_sent=7 after 8 cycles.
3. Only fifo 2 non-empty, fifo_empty=4'b1011 held -> pop=0100 every other cycle, 0000 in between.
4. Traffic active, out_almost_full=1 for 3 cycles -> pop=0 in those cycles; one trailing push; round-robin resumes at the next index after last_grant.
5. Traffic active, then init=1 -> state=INIT next cycle, pop=0, pending push completes. umbral_bajo_in=1/umbral_alto_in=7 latched. init=0 -> resumes ACTIVE.
6. fifo_error=4'b0010 during ACTIVE -> state=ERROR and error_out=1 next cycle; pop stays 0 after error clears; reset low returns to RESET with all outputs 0.
